sliding_window_gen: RTL
=======================

// Module: sliding_window_gen
// PURPOSE
//  Parametrised KxK sliding-window generator for the BNN conv front end. Accepts a raster-order
//  pixel stream (one pixel per accepted beat) of an IMG_W x IMG_H frame. Holds K-1 line buffers
//  plus a KxK register array, and presents a full KxK window, flagged valid, for every in-image
//  window position (no padding, stride 1). It sits between the pixel source and the binary conv PE.
// PARAMETERS
//  DW     8   pixel width in bits
//  K      5   kernel size; legal range 2 <= K <= min(IMG_W, IMG_H)
//  IMG_W  28  frame width in pixels
//  IMG_H  28  frame height in pixels
// PORTS
//  clk        in   1         clock; all logic is on the rising edge
//  rst        in   1         synchronous reset, active-high
//  start      in   1         arms one frame; sampled only in IDLE
//  din_valid  in   1         input pixel qualifier
//  din        in   DW        pixel, raster order (row-major, top-left first)
//  in_ready   out  1         1 in FILL/RUN; a beat is accepted iff din_valid && in_ready
//  win        out  K*K*DW    window; win[(r*K+c)*DW +: DW], r=0 is the top row, c=0 the left column
//  win_valid  out  1         win holds a complete in-image window this cycle
//  frame_done out  1         one-cycle pulse after the last pixel of a frame is accepted
//  busy       out  1         1 when the state is not IDLE
// BEHAVIOUR
//  Reset: state=IDLE; row, col = 0; in_ready=0, win_valid=0, frame_done=0, busy=0; win=0.
//   The line-buffer RAM is not cleared.
//  FSM:
//   IDLE -> FILL on start.
//   FILL -> RUN when the last pixel of row K-2 is accepted.
//   FILL or RUN -> IDLE when pixel (IMG_H-1, IMG_W-1) is accepted.
//  start outside IDLE is ignored. din_valid in IDLE is ignored and nothing is written.
//  Counters: col runs 0..IMG_W-1 and wraps to 0, incrementing row. Both advance only on an
//   accepted beat. Both clear to 0 on start. Widths are $clog2 of IMG_W and IMG_H (minimum 1).
//  Accepted beat at (row, col):
//   - Column shift: the window shifts left one column.
//   - New right column: {line_buf[K-2..0][col], din}, oldest line at r=0.
//   - Line buffers: din is pushed into the line-buffer chain at address col
//     (read-before-write at the same address).
//  Latency: 1 cycle. win/win_valid update in the cycle after the accepting edge, with the new
//   pixel at r=K-1, c=K-1.
//  win_valid=1 for exactly one cycle per accepted beat with row>=K-1 and col>=K-1. It is 0 otherwise,
//   including windows that straddle a row wrap (col<K-1).
//  win holds its value while no beat is accepted. Gaps in din_valid change only timing, never
//   window contents.
//  Windows per frame: (IMG_W-K+1)*(IMG_H-K+1).
//  frame_done: asserted the cycle after the final accepted beat, in the same cycle as the final
//   win_valid. busy and in_ready are already 0 in that cycle. A new start is accepted from that
//   cycle onward.
//  rst mid-frame: the frame is abandoned immediately with reset values; no frame_done is issued.
//   The next start begins a clean frame; stale line-buffer data never reaches a valid window.
// TESTING
//  T1 ramp frame with defaults:
//   Stimulus: start, then pixel (r,c) = (r*28+c)&8'hFF with din_valid=1 continuously.
//   Required: first win_valid 1 cycle after beat 116 (4*28+4); win[0]=8'd0, win[24]=8'd116,
//    win[4]=8'd4, win[20]=8'd112.
//   Required: exactly 576 win_valid pulses; frame_done 1 cycle after beat 783.
//  T2 same ramp with a random ~50% din_valid duty.
//   Required: the identical sequence of 576 windows as T1; win stable between accepted beats.
//  T3 din_valid=1 and din=8'hAA for 10 cycles while in IDLE.
//   Required: in_ready=0, win_valid=0, busy=0; a subsequent T1 frame gives T1 results.
//  T4 assert rst at beat 300 of a frame, then start, then a full ramp frame.
//   Required: outputs 0 in the cycle after rst; no frame_done for the aborted frame; second frame
//    matches T1.
//  T5 start pulses at beats 10 and 500 of a running frame.
//   Required: ignored; counts and windows identical to T1.
//  T6 back-to-back frames (start in the frame_done cycle); second frame ramp offset +8'd50.
//   Required: 576 windows per frame; first window of frame 2 has win[0]=8'd50.
//  T7 K=3, IMG_W=8, IMG_H=6 build, ramp stimulus.
//   Required: 24 windows; first win_valid after beat 18 with win[8]=8'd18.

Source files
------------

// File: rtl/sliding_window_gen.sv
// sliding_window_gen
//   KxK sliding-window generator for a raster-order pixel stream of an
//   IMG_W x IMG_H frame. K-1 line buffers feed the right-hand column of a
//   KxK register window. A full window (no padding, stride 1) is flagged
//   valid for every in-image position, one cycle after the beat completing it.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              arms one frame (sampled only while idle)
//   din_valid, din     pixel beat; accepted iff din_valid && in_ready
//   in_ready           high while a frame is being filled/run
//   win                window, win[(r*K+c)*DW +: DW], r=0 top row, c=0 left column
//   win_valid          win holds a complete in-image window this cycle
//   frame_done         one-cycle pulse after the last pixel of a frame is accepted
//   busy               high whenever the FSM is not idle
module sliding_window_gen #(
  parameter int DW    = 8,
  parameter int K     = 5,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              din_valid,
  input  logic [DW-1:0]     din,
  output logic              in_ready,
  output logic [K*K*DW-1:0] win,
  output logic              win_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned KU = K;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, last_col, last_pix;

  // lb_q[0] holds the previous row, lb_q[K-2] the oldest one.
  logic [DW-1:0] lb_q   [K-1][IMG_W];
  logic [DW-1:0] win_q  [K][K];
  logic [DW-1:0] newcol [K];

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    in_ready     = (state_q == FILL) || (state_q == RUN);
    busy         = (state_q != IDLE);
    accept       = din_valid && in_ready;
    last_col     = (col_q == CW'(IMG_W - 1));
    last_pix     = last_col && (row_q == RW'(IMG_H - 1));
    win_valid_d  = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    frame_done_d = accept && last_pix;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL, RUN: begin
        if (accept) begin
          col_d = last_col ? '0 : col_q + 1'b1;
          if (last_col) row_d = row_q + 1'b1;
          if (last_pix) begin
            state_d = IDLE;
            row_d   = '0;
          end else if ((state_q == FILL) && last_col && (row_q == RW'(K - 2))) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Incoming column: line buffers read at col (before this beat's write), din at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < KU; r++) newcol[r] = '0;
    newcol[K-1] = din;
    for (int unsigned r = 0; r < KU - 1; r++) newcol[r] = lb_q[KU-2-r][col_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned r = 0; r < KU; r++)
        for (int unsigned c = 0; c < KU; c++)
          win_q[r][c] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (accept) begin
        for (int unsigned r = 0; r < KU; r++) begin
          for (int unsigned c = 0; c < KU - 1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][K-1] <= newcol[r];
        end
      end
    end
  end

  // Line-buffer storage is deliberately not reset; every row read into a
  // valid window has been rewritten earlier in the same frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= din;
      for (int unsigned i = 1; i < KU - 1; i++) lb_q[i][col_q] <= lb_q[i-1][col_q];
    end
  end

  always_comb begin
    win = '0;
    for (int unsigned r = 0; r < KU; r++)
      for (int unsigned c = 0; c < KU; c++)
        win[(r*KU+c)*DW +: DW] = win_q[r][c];
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule
